// File: rtl/sprite_hop_ctrl.sv
// sprite_hop_ctrl
//   Position controller for the player sprite in the VGA game layer.
//   The sprite moves in discrete hops of HOP_DIST pixels, split into
//   HOP_STEPS animation steps (one per timer_done tick).
//   River-current drift, teleport (jump) and respawn (reset_position)
//   are layered on top.
//   ObjectStartX/ObjectStartY give the top-left pixel of the sprite.
//
//   Optional build macro SPRITE_HOP_WRAP_X_EN: when defined, X wraps
//   around the frame instead of clamping. Y always clamps.
//
//   Handshake: there is no valid/ready pair. Inputs are qualified per CLK.
//   timer_done is a 1-CLK strobe. reset_position and jump are sampled on
//   every CLK with priority reset_position > jump > timer_done.
//   The outputs update on the CLK edge that consumes one of these events.
//   hop_done is high for exactly the CLK following a final hop step.
//
//   Debug: dbg_state exposes the FSM state (0 = IDLE, 1 = HOP).
//   dbg_step_cnt exposes the hop step counter.
`timescale 1ns/1ps

module sprite_hop_ctrl #(
  parameter int COORD_W     = 11,
  parameter int FRAME_W     = 640,
  parameter int FRAME_H     = 480,
  parameter int SPRITE_SIZE = 20,
  parameter int HOP_DIST    = 20,
  parameter int HOP_STEPS   = 4,
  parameter int START_X     = 320,
  parameter int START_Y     = 440
) (
  input  logic               CLK,
  input  logic               RESETn,
  input  logic               timer_done,
  input  logic               reset_position,
  input  logic               jump,
  input  logic [COORD_W-1:0] jump_x,
  input  logic [COORD_W-1:0] jump_y,
  input  logic               up,
  input  logic               down,
  input  logic               left,
  input  logic               right,
  input  logic               drift_en,
  input  logic               drift_left,
  input  logic [2:0]         drift_speed,
  output logic [COORD_W-1:0] ObjectStartX,
  output logic [COORD_W-1:0] ObjectStartY,
  output logic               hopping,
  output logic [1:0]         hop_dir,
  output logic               hop_done,
  output logic               at_edge,
  output logic               dbg_state,
  output logic [$clog2(HOP_STEPS+1)-1:0] dbg_step_cnt
);

  // Elaboration-time sanity: a hop must split into whole-pixel steps.
  generate
    if (HOP_STEPS < 1) begin : g_bad_steps
      $error("sprite_hop_ctrl: HOP_STEPS must be at least 1");
    end
    if ((HOP_DIST % HOP_STEPS) != 0) begin : g_bad_dist
      $error("sprite_hop_ctrl: HOP_DIST must be a multiple of HOP_STEPS");
    end
  endgenerate

  localparam int STEP  = HOP_DIST / HOP_STEPS;
  localparam int SW    = COORD_W + 2;
  localparam int CNT_W = $clog2(HOP_STEPS + 1);

  localparam logic signed [SW-1:0] STEP_S  = SW'(STEP);
  localparam logic signed [SW-1:0] MAX_X_S = SW'(FRAME_W - SPRITE_SIZE);
  localparam logic signed [SW-1:0] MAX_Y_S = SW'(FRAME_H - SPRITE_SIZE);
`ifdef SPRITE_HOP_WRAP_X_EN
  localparam logic signed [SW-1:0] FRAME_W_S  = SW'(FRAME_W);
  localparam logic signed [SW-1:0] FRAME_W_M1 = SW'(FRAME_W - 1);
`endif

  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_DOWN  = 2'd1;
  localparam logic [1:0] DIR_LEFT  = 2'd2;
  localparam logic [1:0] DIR_RIGHT = 2'd3;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_HOP  = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   step_cnt_q, step_cnt_d;
  logic [1:0]         hop_dir_q, hop_dir_d;

  logic [COORD_W-1:0] pos_x_q, pos_y_q;
  logic               hop_done_q, at_edge_q;

  logic               key_any;
  logic [1:0]         key_dir;

  // Outputs of the FSM output decode.
  logic               move_en;
  logic [1:0]         move_dir;
  logic               last_step;

  // Datapath intermediates.
  logic signed [SW-1:0] hop_dx, hop_dy, drift_dx;
  logic signed [SW-1:0] sum_x, sum_y, bound_x, bound_y;
  logic                 x_clamped, y_clamped;

  // Key direction priority when several keys are held: up > down > left > right.
  always_comb begin
    key_any = up | down | left | right;
    if (up)        key_dir = DIR_UP;
    else if (down) key_dir = DIR_DOWN;
    else if (left) key_dir = DIR_LEFT;
    else           key_dir = DIR_RIGHT;
  end

  // FSM state register: hop state, step counter and latched direction.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state_q    <= S_IDLE;
      step_cnt_q <= '0;
      hop_dir_q  <= DIR_UP;
    end else begin
      state_q    <= state_d;
      step_cnt_q <= step_cnt_d;
      hop_dir_q  <= hop_dir_d;
    end
  end

  // FSM next-state: respawn/teleport abort a hop; ticks advance it.
  always_comb begin
    state_d    = state_q;
    step_cnt_d = step_cnt_q;
    hop_dir_d  = hop_dir_q;
    if (reset_position || jump) begin
      state_d    = S_IDLE;
      step_cnt_d = '0;
    end else if (timer_done) begin
      case (state_q)
        S_IDLE: begin
          if (key_any) begin
            hop_dir_d = key_dir;
            if (HOP_STEPS == 1) begin
              state_d    = S_IDLE;
              step_cnt_d = '0;
            end else begin
              state_d    = S_HOP;
              step_cnt_d = CNT_W'(1);
            end
          end
        end
        S_HOP: begin
          if (step_cnt_q == CNT_W'(HOP_STEPS - 1)) begin
            state_d    = S_IDLE;
            step_cnt_d = '0;
          end else begin
            step_cnt_d = step_cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d    = S_IDLE;
          step_cnt_d = '0;
        end
      endcase
    end
  end

  // FSM output decode.
  // Decides whether this tick moves the sprite, in which direction,
  // and whether the tick is the final step of the hop.
  always_comb begin
    move_en   = 1'b0;
    move_dir  = hop_dir_q;
    last_step = 1'b0;
    if (!reset_position && !jump && timer_done) begin
      case (state_q)
        S_IDLE: begin
          if (key_any) begin
            move_en   = 1'b1;
            move_dir  = key_dir;
            last_step = (HOP_STEPS == 1);
          end
        end
        S_HOP: begin
          move_en   = 1'b1;
          last_step = (step_cnt_q == CNT_W'(HOP_STEPS - 1));
        end
        default: begin
          move_en = 1'b0;
        end
      endcase
    end
  end

  // Per-tick displacement.
  // The hop step and the drift are summed before a single bounding pass,
  // so drift cannot push the sprite through an edge the hop was clamped at.
  always_comb begin
    hop_dx   = '0;
    hop_dy   = '0;
    drift_dx = '0;
    if (move_en) begin
      case (move_dir)
        DIR_UP:   hop_dy = -STEP_S;
        DIR_DOWN: hop_dy = STEP_S;
        DIR_LEFT: hop_dx = -STEP_S;
        default:  hop_dx = STEP_S;
      endcase
    end
    if (drift_en) begin
      if (drift_left) drift_dx = -$signed({{(SW-3){1'b0}}, drift_speed});
      else            drift_dx =  $signed({{(SW-3){1'b0}}, drift_speed});
    end
    sum_x = $signed({2'b00, pos_x_q}) + hop_dx + drift_dx;
    sum_y = $signed({2'b00, pos_y_q}) + hop_dy;
  end

  // Bounding.
  // Y always clamps to the visible area. X clamps by default,
  // or wraps once around the frame when SPRITE_HOP_WRAP_X_EN is defined.
  always_comb begin
    bound_x   = sum_x;
    bound_y   = sum_y;
    x_clamped = 1'b0;
    y_clamped = 1'b0;
`ifdef SPRITE_HOP_WRAP_X_EN
    if (sum_x[SW-1])             bound_x = sum_x + FRAME_W_S;
    else if (sum_x > FRAME_W_M1) bound_x = sum_x - FRAME_W_S;
`else
    if (sum_x[SW-1]) begin
      bound_x   = '0;
      x_clamped = 1'b1;
    end else if (sum_x > MAX_X_S) begin
      bound_x   = MAX_X_S;
      x_clamped = 1'b1;
    end
`endif
    if (sum_y[SW-1]) begin
      bound_y   = '0;
      y_clamped = 1'b1;
    end else if (sum_y > MAX_Y_S) begin
      bound_y   = MAX_Y_S;
      y_clamped = 1'b1;
    end
  end

  // Position and status registers.
  // Priority is respawn, then teleport, then the motion tick.
  // hop_done drops on any CLK without an event.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      pos_x_q    <= COORD_W'(START_X);
      pos_y_q    <= COORD_W'(START_Y);
      hop_done_q <= 1'b0;
      at_edge_q  <= 1'b0;
    end else if (reset_position) begin
      pos_x_q    <= COORD_W'(START_X);
      pos_y_q    <= COORD_W'(START_Y);
      hop_done_q <= 1'b0;
      at_edge_q  <= 1'b0;
    end else if (jump) begin
      pos_x_q    <= jump_x;
      pos_y_q    <= jump_y;
      hop_done_q <= 1'b0;
      at_edge_q  <= 1'b0;
    end else if (timer_done) begin
      pos_x_q    <= bound_x[COORD_W-1:0];
      pos_y_q    <= bound_y[COORD_W-1:0];
      hop_done_q <= last_step;
      at_edge_q  <= x_clamped | y_clamped;
    end else begin
      hop_done_q <= 1'b0;
    end
  end

  assign ObjectStartX = pos_x_q;
  assign ObjectStartY = pos_y_q;
  assign hopping      = (state_q == S_HOP);
  assign hop_dir      = hop_dir_q;
  assign hop_done     = hop_done_q;
  assign at_edge      = at_edge_q;
  assign dbg_state    = state_q;
  assign dbg_step_cnt = step_cnt_q;

endmodule

// File: tb/tb_sprite_hop_ctrl.sv
// tb_sprite_hop_ctrl
//   Bench for sprite_hop_ctrl at default parameters (STEP = 5).
//
//   Stimulus is driven on the falling edge. Every respawn, teleport or tick
//   is applied to a behavioural model of the sprite, which tracks position
//   and the number of hop steps left. The model's expected outputs are
//   queued in exp_q.
//
//   A monitor runs 2 ns after each rising edge. It pops and compares the
//   queue whenever an event was presented to the DUT, and checks that
//   hop_done is low otherwise.
//
//   Directed scenarios use spot checks against hand-computed constants.
//   A random phase follows.
`timescale 1ns/1ps

module tb_sprite_hop_ctrl;

  localparam int COORD_W     = 11;
  localparam int FRAME_W     = 640;
  localparam int FRAME_H     = 480;
  localparam int SPRITE_SIZE = 20;
  localparam int HOP_DIST    = 20;
  localparam int HOP_STEPS   = 4;
  localparam int START_X     = 320;
  localparam int START_Y     = 440;
  localparam int STEP        = HOP_DIST / HOP_STEPS;
  localparam int CNT_W       = $clog2(HOP_STEPS + 1);
  localparam int OW          = 2 * COORD_W + 5;

  localparam logic [3:0] K_NONE  = 4'b0000;
  localparam logic [3:0] K_UP    = 4'b1000;
  localparam logic [3:0] K_LEFT  = 4'b0010;
  localparam logic [3:0] K_RIGHT = 4'b0001;

  // ---------------- clock / reset ----------------
  logic               CLK = 1'b0;
  logic               RESETn = 1'b0;
  logic               timer_done = 1'b0;
  logic               reset_position = 1'b0;
  logic               jump = 1'b0;
  logic [COORD_W-1:0] jump_x = '0;
  logic [COORD_W-1:0] jump_y = '0;
  logic               up = 1'b0, down = 1'b0, left = 1'b0, right = 1'b0;
  logic               drift_en = 1'b0, drift_left = 1'b0;
  logic [2:0]         drift_speed = '0;
  logic [COORD_W-1:0] ObjectStartX, ObjectStartY;
  logic               hopping, hop_done, at_edge, dbg_state;
  logic [1:0]         hop_dir;
  logic [CNT_W-1:0]   dbg_step_cnt;

  always #5 CLK = ~CLK;

  sprite_hop_ctrl #(
    .COORD_W(COORD_W), .FRAME_W(FRAME_W), .FRAME_H(FRAME_H),
    .SPRITE_SIZE(SPRITE_SIZE), .HOP_DIST(HOP_DIST), .HOP_STEPS(HOP_STEPS),
    .START_X(START_X), .START_Y(START_Y)
  ) dut (
    .CLK(CLK), .RESETn(RESETn), .timer_done(timer_done),
    .reset_position(reset_position), .jump(jump),
    .jump_x(jump_x), .jump_y(jump_y),
    .up(up), .down(down), .left(left), .right(right),
    .drift_en(drift_en), .drift_left(drift_left), .drift_speed(drift_speed),
    .ObjectStartX(ObjectStartX), .ObjectStartY(ObjectStartY),
    .hopping(hopping), .hop_dir(hop_dir), .hop_done(hop_done),
    .at_edge(at_edge), .dbg_state(dbg_state), .dbg_step_cnt(dbg_step_cnt)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [OW-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Position plus the number of hop steps still to play out.
  int   m_x, m_y, m_left, m_dir;
  logic m_done, m_edge;

  task automatic model_reset();
    m_x = START_X; m_y = START_Y; m_left = 0; m_dir = 0;
    m_done = 1'b0; m_edge = 1'b0;
  endtask

  task automatic model_step(input logic t, input logic [3:0] k, input logic de,
                            input logic dl, input logic [2:0] ds, input logic j,
                            input int jx, input int jy, input logic rp);
    int dx, dy, nx, ny;
    if (rp) begin
      m_x = START_X; m_y = START_Y; m_left = 0; m_done = 1'b0; m_edge = 1'b0;
    end else if (j) begin
      m_x = jx; m_y = jy; m_left = 0; m_done = 1'b0; m_edge = 1'b0;
    end else if (t) begin
      dx = 0; dy = 0; m_done = 1'b0; m_edge = 1'b0;
      if (m_left == 0 && k != 4'b0000) begin
        m_dir  = k[3] ? 0 : (k[2] ? 1 : (k[1] ? 2 : 3));
        m_left = HOP_STEPS;
      end
      if (m_left > 0) begin
        case (m_dir)
          0:       dy = -STEP;
          1:       dy = STEP;
          2:       dx = -STEP;
          default: dx = STEP;
        endcase
        m_left--;
        m_done = (m_left == 0);
      end
      if (de) dx += dl ? -int'(ds) : int'(ds);
      nx = m_x + dx;
      ny = m_y + dy;
`ifdef SPRITE_HOP_WRAP_X_EN
      if (nx < 0) nx += FRAME_W;
      else if (nx > FRAME_W - 1) nx -= FRAME_W;
`else
      if (nx < 0) begin nx = 0; m_edge = 1'b1; end
      else if (nx > FRAME_W - SPRITE_SIZE) begin nx = FRAME_W - SPRITE_SIZE; m_edge = 1'b1; end
`endif
      if (ny < 0) begin ny = 0; m_edge = 1'b1; end
      else if (ny > FRAME_H - SPRITE_SIZE) begin ny = FRAME_H - SPRITE_SIZE; m_edge = 1'b1; end
      m_x = nx; m_y = ny;
    end
  endtask

  function automatic logic [OW-1:0] model_pack();
    return {COORD_W'(m_x), COORD_W'(m_y), (m_left > 0), 2'(m_dir), m_done, m_edge};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive(input logic t, input logic [3:0] k, input logic de, input logic dl,
                       input logic [2:0] ds, input logic j, input int jx, input int jy,
                       input logic rp);
    @(negedge CLK);
    timer_done = t;
    {up, down, left, right} = k;
    drift_en = de; drift_left = dl; drift_speed = ds;
    jump = j; jump_x = COORD_W'(jx); jump_y = COORD_W'(jy);
    reset_position = rp;
    model_step(t, k, de, dl, ds, j, jx, jy, rp);
    if (t || j || rp) exp_q.push_back(model_pack());
  endtask

  // One tick then one quiet cycle, keys held throughout.
  // Returns at the falling edge where the tick's result is visible.
  task automatic tick(input logic [3:0] k, input logic de, input logic dl, input logic [2:0] ds);
    drive(1'b1, k, de, dl, ds, 1'b0, 0, 0, 1'b0);
    drive(1'b0, k, de, dl, ds, 1'b0, 0, 0, 1'b0);
  endtask

  task automatic do_jump(input int jx, input int jy);
    drive(1'b0, K_NONE, 1'b0, 1'b0, 3'd0, 1'b1, jx, jy, 1'b0);
    drive(1'b0, K_NONE, 1'b0, 1'b0, 3'd0, 1'b0, 0, 0, 1'b0);
  endtask

  // ---------------- monitor ----------------
  always @(posedge CLK) begin : monitor
    logic          ev;
    logic [OW-1:0] exp_v;
    logic [OW-1:0] act_v;
    ev = timer_done | jump | reset_position;
    #2;
    if (ev) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL monitor_underflow: DUT event with empty expected queue at %0t", $time);
      end else begin
        exp_v = exp_q.pop_front();
        act_v = {ObjectStartX, ObjectStartY, hopping, hop_dir, hop_done, at_edge};
        check("outputs{x,y,hopping,dir,done,edge}", 32'(act_v), 32'(exp_v));
      end
    end else if (RESETn) begin
      check("hop_done_self_clear", 32'(hop_done), 32'd0);
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin : main
    int   exp_y;
    logic prev_t;
    logic t, j, rp, de, dl;
    logic [3:0] k;
    logic [2:0] ds;
    int   jx, jy;

    model_reset();
    repeat (3) @(negedge CLK);
    check("reset_x", 32'(ObjectStartX), 32'd320);
    check("reset_y", 32'(ObjectStartY), 32'd440);
    check("reset_flags{hopping,dir,done,edge}", 32'({hopping, hop_dir, hop_done, at_edge}), 32'd0);
    RESETn = 1'b1;

    // T2: up held across the hop, and a seamless restart on the 5th tick.
    exp_y = 440;
    for (int i = 0; i < 5; i++) begin
      tick(K_UP, 1'b0, 1'b0, 3'd0);
      exp_y -= 5;
      check("t2_y", 32'(ObjectStartY), 32'(exp_y));
      check("t2_hop_done", 32'(hop_done), (i == 3) ? 32'd1 : 32'd0);
    end
    for (int i = 0; i < 3; i++) tick(K_NONE, 1'b0, 1'b0, 3'd0);
    check("t2_end_y", 32'(ObjectStartY), 32'd400);
    check("t2_end_hop_done", 32'(hop_done), 32'd1);
    check("t2_end_hopping", 32'(hopping), 32'd0);

    // T1: asynchronous reset in the middle of a hop.
    tick(K_UP, 1'b0, 1'b0, 3'd0);
    check("t1_pre_hopping", 32'(hopping), 32'd1);
    #2 RESETn = 1'b0;
    #1;
    check("t1_async_x", 32'(ObjectStartX), 32'd320);
    check("t1_async_y", 32'(ObjectStartY), 32'd440);
    check("t1_async_hopping", 32'(hopping), 32'd0);
    check("t1_async_hop_done", 32'(hop_done), 32'd0);
    model_reset();
    @(negedge CLK);
    RESETn = 1'b1;

    // T4: drift only, no keys.
    for (int i = 0; i < 3; i++) begin
      tick(K_NONE, 1'b1, 1'b1, 3'd1);
      check("t4_x", 32'(ObjectStartX), 32'(319 - i));
      check("t4_hopping", 32'(hopping), 32'd0);
    end

    // T3: tap left at X=2, the hop clamps at the edge.
    do_jump(2, 300);
    tick(K_LEFT, 1'b0, 1'b0, 3'd0);
`ifdef SPRITE_HOP_WRAP_X_EN
    check("t3_x_wrap", 32'(ObjectStartX), 32'd637);
    check("t3_edge_wrap", 32'(at_edge), 32'd0);
`else
    check("t3_x", 32'(ObjectStartX), 32'd0);
    check("t3_edge", 32'(at_edge), 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick(K_NONE, 1'b0, 1'b0, 3'd0);
      check("t3_x_hold", 32'(ObjectStartX), 32'd0);
      check("t3_hop_done", 32'(hop_done), (i == 2) ? 32'd1 : 32'd0);
    end
`endif

    // T5: right hop with drift, then teleport mid-hop,
    // then teleport and respawn on the same CLK.
    do_jump(300, 440);
    for (int i = 0; i < 4; i++) begin
      tick(K_RIGHT, 1'b1, 1'b0, 3'd2);
      check("t5_x", 32'(ObjectStartX), 32'(307 + 7 * i));
    end
    tick(K_RIGHT, 1'b0, 1'b0, 3'd0);
    do_jump(100, 200);
    check("t5_jump_xy", 32'({ObjectStartX, ObjectStartY}), 32'({11'd100, 11'd200}));
    check("t5_jump_flags", 32'({hopping, hop_done}), 32'd0);
    drive(1'b0, K_NONE, 1'b0, 1'b0, 3'd0, 1'b1, 50, 60, 1'b1);
    drive(1'b0, K_NONE, 1'b0, 1'b0, 3'd0, 1'b0, 0, 0, 1'b0);
    check("t5_rp_over_jump", 32'({ObjectStartX, ObjectStartY}), 32'({11'd320, 11'd440}));

    // T6: drift left from X=0.
    do_jump(0, 100);
    tick(K_NONE, 1'b1, 1'b1, 3'd1);
`ifdef SPRITE_HOP_WRAP_X_EN
    check("t6_x", 32'(ObjectStartX), 32'd639);
    check("t6_edge", 32'(at_edge), 32'd0);
`else
    check("t6_x", 32'(ObjectStartX), 32'd0);
    check("t6_edge", 32'(at_edge), 32'd1);
`endif

    // Random phase: keys, drift, ticks, teleports and respawns.
    prev_t = 1'b0;
    for (int i = 0; i < 600; i++) begin
      t  = !prev_t && ($urandom_range(0, 2) != 0);
      k  = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'(1 << $urandom_range(0, 3));
      if ($urandom_range(0, 4) == 0) k = K_NONE;
      de = ($urandom_range(0, 1) == 1);
      dl = ($urandom_range(0, 1) == 1);
      ds = 3'($urandom_range(0, 7));
      j  = ($urandom_range(0, 39) == 0);
      rp = ($urandom_range(0, 69) == 0);
      case ($urandom_range(0, 3))
        0:       jx = $urandom_range(0, 10);
        1:       jx = $urandom_range(610, 700);
        default: jx = $urandom_range(0, 639);
      endcase
      jy = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 12) : $urandom_range(440, 500);
      drive(t, k, de, dl, ds, j, jx, jy, rp);
      prev_t = t;
    end

    repeat (3) drive(1'b0, K_NONE, 1'b0, 1'b0, 3'd0, 1'b0, 0, 0, 1'b0);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
